rx_deframer_fifo: RTL and testbench
===================================

Name: rx_deframer_fifo

Overview:
Parametrised UART receive deframer, successor to the fixed 8-bit deframer.
- Accepts a complete parallel frame from the Rx shift stage and strips the start, parity and stop bits.
- Checks parity, start bit and stop bit(s), and tags each received character with error flags.
- Buffers characters in a FIFO with a valid/ready output handshake.
- Sits between the Rx shift register/bit sampler and the host-side Rx data interface.

Parameters:
- DATA_W_MAX, 8, maximum data bits per character; out_data width.
- FRAME_W, 12, width of frame_in; must be ≥ 1+DATA_W_MAX+1+2.
- FIFO_DEPTH, 4, number of buffered characters; power of two, ≥ 2.
- CNT_W, 3, width of fill_level; clog2(FIFO_DEPTH)+1.

Ports:
- Clk  in  1  rising-edge clock.
- ResetN  in  1  asynchronous, active-low reset.
- cfg_data_len  in  4  data bits per character; legal 5..DATA_W_MAX.
- cfg_parity  in  2  00 none, 01 odd, 10 even, 11 none.
- cfg_stop2  in  1  1 = two stop bits checked.
- frame_valid  in  1  single-cycle strobe: frame_in holds a full frame.
- frame_in  in  FRAME_W  received frame; bit0 = start bit, LSB-first.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  DATA_W_MAX  data bits, zero-extended above cfg_data_len.
- out_perr  out  1  parity error for the head character.
- out_ferr  out  1  framing error (start ≠ 0 or any checked stop ≠ 1) for the head character.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- overrun_clr  in  1  clears overrun.
- fill_level  out  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (ResetN=0, async):
  - FIFO emptied: read/write pointers and count = 0.
  - out_valid=0, out_data=0, out_perr=0, out_ferr=0, overrun=0, fill_level=0.
  - Reset asserted mid-stream discards all buffered characters.
- Frame decode (combinational from frame_in and cfg_*, sampled on the frame_valid edge):
  - Let L = cfg_data_len.
  - data = frame_in[L:1].
  - If parity is enabled: p = frame_in[L+1]; stop bits start at index L+2. Otherwise stop bits start at index L+1.
  - perr: odd mode, perr=1 when XOR(data, p) ≠ 1; even mode, perr=1 when XOR(data, p) ≠ 0; perr=0 when parity is disabled.
  - ferr = frame_in[0] | ~stop0 | (cfg_stop2 & ~stop1).
  - Frame bits above the last stop bit are ignored.
- Illegal L (<5 or >DATA_W_MAX): the frame is still pushed, with L clamped into 5..DATA_W_MAX and ferr forced to 1.
- Push: on a rising edge with frame_valid=1 and FIFO not full, {data, perr, ferr} is written at the write pointer, which then increments modulo FIFO_DEPTH.
- Pop: on a rising edge with out_valid & out_ready, the read pointer increments modulo FIFO_DEPTH.
- Latency: frame_valid at edge N into an empty FIFO gives out_valid=1 after edge N, i.e. visible in cycle N+1. There is no bypass path.
- Output registers: out_data, out_perr and out_ferr reflect the FIFO head and are held stable while out_valid=1 and out_ready=0. Their value when out_valid=0 is don't-care; the bench must not check it.
- Full FIFO:
  - frame_valid with no simultaneous pop: the frame is dropped and overrun is set.
  - frame_valid with a simultaneous pop: the push is accepted, count is unchanged, no overrun.
- Empty FIFO: out_ready is ignored and the pointers are unchanged.
- Simultaneous push and pop when not full or empty: count is unchanged.
- Overrun flag: stays set until overrun_clr=1 on an edge. If a drop and overrun_clr occur on the same edge, the set wins (overrun stays 1).
- Pointer wrap: pointers wrap modulo FIFO_DEPTH. fill_level is tracked by a separate counter and saturates at neither end; FIFO logic guarantees 0..FIFO_DEPTH.
- Config changes: changes take effect on the next frame_valid. Already-buffered entries are unaffected.

Test Plan:
- 8N1 basic: L=8, parity=00, stop2=0, frame_in=12'h2A4 (start 0, data 0x52, stop 1) → one cycle later out_valid=1, out_data=8'h52, perr=0, ferr=0; out_ready=1 → out_valid=0, fill_level=0.
- 7E1 parity: L=7, even, data 7'h41 with parity bit 1 → perr=1. Same data with parity bit 0 → perr=0; out_data=8'h41 (bit7 = 0).
- 5O2 stop check: L=5, odd, stop2=1, second stop bit = 0 → ferr=1. Start bit = 1 with valid stops → ferr=1.
- Overrun: FIFO_DEPTH=4, out_ready=0, 5 frames with data 0x01..0x05 → fill_level=4, overrun=1; pops return 0x01..0x04 in order; overrun_clr → overrun=0.
- Full with simultaneous push and pop: FIFO full, frame_valid and out_ready on the same edge → fill_level stays 4, overrun stays 0, new data appears last. Then reset asserted mid-burst → out_valid=0, fill_level=0 immediately, without waiting for a clock edge.
- Illegal length: cfg_data_len=4 → character pushed with ferr=1 and data decoded as L=5; cfg_data_len=9 with DATA_W_MAX=8 → decoded as L=8, ferr=1.

Source files
------------

// File: rtl/rx_deframer_fifo.sv
// UART receive deframer: strips start/parity/stop bits from a parallel frame,
// flags parity/framing errors and buffers characters in a small valid/ready FIFO.
module rx_deframer_fifo #(
    parameter int DATA_W_MAX = 8,
    parameter int FRAME_W    = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    input  logic [3:0]            cfg_data_len,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop2,
    input  logic                  frame_valid,
    input  logic [FRAME_W-1:0]    frame_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W_MAX-1:0] out_data,
    output logic                  out_perr,
    output logic                  out_ferr,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic [CNT_W-1:0]      fill_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = DATA_W_MAX + 2;

    logic [ENT_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [CNT_W-1:0]      count;

    int                    lEff;
    int                    stopIdx;
    logic                  lenIllegal;
    logic                  parityEn;
    logic [DATA_W_MAX-1:0] decData;
    logic                  parBit;
    logic                  stop0;
    logic                  stop1;
    logic                  decPerr;
    logic                  decFerr;

    logic                  full;
    logic                  doPop;
    logic                  doPush;
    logic                  doDrop;

    // Out-of-range lengths are clamped so the character still lands in the FIFO,
    // but it is always tagged as a framing error.
    always_comb begin
        lenIllegal = 1'b0;
        lEff       = int'(cfg_data_len);
        if (cfg_data_len < 4'd5) begin
            lenIllegal = 1'b1;
            lEff       = 5;
        end else if (int'(cfg_data_len) > DATA_W_MAX) begin
            lenIllegal = 1'b1;
            lEff       = DATA_W_MAX;
        end

        parityEn = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
        stopIdx  = parityEn ? lEff + 2 : lEff + 1;

        decData = '0;
        for (int i = 0; i < DATA_W_MAX; i++) begin
            if (i < lEff) decData[i] = frame_in[i+1];
        end

        parBit = 1'b0;
        stop0  = 1'b0;
        stop1  = 1'b0;
        for (int i = 0; i < FRAME_W; i++) begin
            if (i == lEff + 1)      parBit = frame_in[i];
            if (i == stopIdx)       stop0  = frame_in[i];
            if (i == stopIdx + 1)   stop1  = frame_in[i];
        end

        case (cfg_parity)
            2'b01:   decPerr = ~(^decData ^ parBit);
            2'b10:   decPerr = ^decData ^ parBit;
            default: decPerr = 1'b0;
        endcase

        decFerr = frame_in[0] | ~stop0 | (cfg_stop2 & ~stop1) | lenIllegal;
    end

    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign doPop  = out_valid & out_ready;
    // A pop on the same edge frees the slot the push needs, so a full FIFO still accepts.
    assign doPush = frame_valid & (~full | doPop);
    assign doDrop = frame_valid & full & ~doPop;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= {decData, decPerr, decFerr};
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) rdPtr <= rdPtr + 1'b1;

            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (doDrop)           overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

    assign out_valid  = (count != '0);
    assign out_data   = mem[rdPtr][ENT_W-1:2];
    assign out_perr   = mem[rdPtr][1];
    assign out_ferr   = mem[rdPtr][0];
    assign fill_level = count;

endmodule

// File: tb/tb_rx_deframer_fifo.sv
// Directed bench for rx_deframer_fifo: stimulus queues expected characters,
// a negedge monitor pops and compares them as the consumer accepts each head.
module tb_rx_deframer_fifo;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic [3:0]  cfg_data_len = 4'd8;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic        frame_valid = 1'b0;
    logic [11:0] frame_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_perr;
    logic        out_ferr;
    logic        overrun;
    logic        overrun_clr = 1'b0;
    logic [2:0]  fill_level;

    int errors = 0;
    int checks = 0;
    logic [9:0] expQ [$];

    always #5 Clk = ~Clk;

    rx_deframer_fifo dut (
        .Clk(Clk), .ResetN(ResetN),
        .cfg_data_len(cfg_data_len), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .frame_valid(frame_valid), .frame_in(frame_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_perr(out_perr), .out_ferr(out_ferr),
        .overrun(overrun), .overrun_clr(overrun_clr), .fill_level(fill_level)
    );

    // The head is accepted on the next rising edge; compare it here.
    always @(negedge Clk) begin
        if (ResetN && out_valid && out_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got data=%h perr=%b ferr=%b, required none", out_data, out_perr, out_ferr);
            end else begin
                logic [9:0] e;
                e = expQ.pop_front();
                if ({out_data, out_perr, out_ferr} !== e) begin
                    errors++;
                    $display("FAIL pop_char: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                             out_data, out_perr, out_ferr, e[9:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic sendFrame(input logic [11:0] f, input logic expectIt, input logic [7:0] d,
                             input logic pe, input logic fe);
        frame_valid = 1'b1;
        frame_in    = f;
        if (expectIt) expQ.push_back({d, pe, fe});
        @(posedge Clk); #1;
        frame_valid = 1'b0;
    endtask

    task automatic popOne();
        out_ready = 1'b1;
        @(posedge Clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (fill_level == 0) break;
            popOne();
        end
        chk(name, {29'd0, fill_level}, 32'd0);
        chk({name, "_queue"}, expQ.size(), 32'd0);
    endtask

    initial begin
        #12;
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_fill", {29'd0, fill_level}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        chk("reset_outs", {22'd0, out_data, out_perr, out_ferr}, 32'd0);
        @(posedge Clk); #1;
        ResetN = 1'b1;
        @(posedge Clk); #1;

        // Ready on an empty FIFO must not disturb anything.
        popOne();
        chk("empty_pop_fill", {29'd0, fill_level}, 32'd0);

        // 8N1
        cfg_data_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        sendFrame(12'h2A4, 1'b1, 8'h52, 1'b0, 1'b0);
        chk("8n1_valid", {31'd0, out_valid}, 32'd1);
        chk("8n1_fill", {29'd0, fill_level}, 32'd1);
        popOne();
        chk("8n1_valid_after_pop", {31'd0, out_valid}, 32'd0);
        chk("8n1_fill_after_pop", {29'd0, fill_level}, 32'd0);

        // 7E1: data 0x41 has even weight, so parity bit 1 is an error
        cfg_data_len = 4'd7; cfg_parity = 2'b10;
        sendFrame(12'h382, 1'b1, 8'h41, 1'b1, 1'b0);
        sendFrame(12'h282, 1'b1, 8'h41, 1'b0, 1'b0);
        drain("7e1_drain");

        // 5O2: data 0x15 has odd weight
        cfg_data_len = 4'd5; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
        sendFrame(12'h0AA, 1'b1, 8'h15, 1'b0, 1'b1);
        sendFrame(12'h1AB, 1'b1, 8'h15, 1'b0, 1'b1);
        sendFrame(12'h1AA, 1'b1, 8'h15, 1'b0, 1'b0);
        sendFrame(12'h1EA, 1'b1, 8'h15, 1'b1, 1'b0);
        chk("5o2_full", {29'd0, fill_level}, 32'd4);
        drain("5o2_drain");

        // Overrun
        cfg_data_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        for (int d = 1; d <= 5; d++)
            sendFrame(12'h200 | 12'(d << 1), d <= 4, 8'(d), 1'b0, 1'b0);
        chk("ovr_fill", {29'd0, fill_level}, 32'd4);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        overrun_clr = 1'b1;
        sendFrame(12'h20C, 1'b0, 8'h06, 1'b0, 1'b0);
        overrun_clr = 1'b0;
        chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
        drain("ovr_drain");
        chk("ovr_still_set", {31'd0, overrun}, 32'd1);
        overrun_clr = 1'b1;
        @(posedge Clk); #1;
        overrun_clr = 1'b0;
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);

        // Full with simultaneous push and pop, then reset mid-burst
        for (int d = 8'h11; d <= 8'h14; d++)
            sendFrame(12'h200 | 12'(d << 1), 1'b1, 8'(d), 1'b0, 1'b0);
        out_ready = 1'b1;
        sendFrame(12'h22A, 1'b1, 8'h15, 1'b0, 1'b0);
        out_ready = 1'b0;
        chk("full_pp_fill", {29'd0, fill_level}, 32'd4);
        chk("full_pp_overrun", {31'd0, overrun}, 32'd0);
        popOne();
        popOne();
        popOne();
        chk("full_pp_last", {22'd0, out_data, out_perr, out_ferr}, {22'd0, 8'h15, 2'b00});
        ResetN = 1'b0;
        #2;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_fill", {29'd0, fill_level}, 32'd0);
        expQ.delete();
        @(posedge Clk); #1;
        ResetN = 1'b1;
        @(posedge Clk); #1;

        // Illegal lengths clamp and force a framing error
        cfg_data_len = 4'd4;
        sendFrame(12'h06A, 1'b1, 8'h15, 1'b0, 1'b1);
        cfg_data_len = 4'd9;
        sendFrame(12'h2A4, 1'b1, 8'h52, 1'b0, 1'b1);
        drain("illegal_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
